cim_unit_ctrl: RTL and testbench

- Parametrised scheduler and datapath mux that sits between the host/sequencer and an array of NUM_CORES CIM cores.
- Generalises the fixed 8-core unit. It replaces silent drop of conflicting standard R/W with valid/ready stalls, and pipelines CIM and read responses with tags.
- It tracks per-core weight-loaded status. STD and CIM traffic to different cores proceeds concurrently.
- Activations are broadcast to the cores outside this block. This block gates per-core CIM enable and routes responses.

---
 rtl/cim_unit_ctrl_if.sv | 51 +++++
 rtl/cim_unit_ctrl.sv | 139 +++++++++++++
 tb/tb_cim_unit_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cim_unit_ctrl_if.sv
// Host-side bundle of cim_unit_ctrl: weight write/read requests, CIM
// requests and the tagged read/PSUM responses.
//
// Handshake rule for every request channel (wr, rd, cim): a beat transfers
// in a cycle where valid and ready are both 1. The requester holds valid and
// its payload until that cycle. Ready may depend on valid and payload in the
// same cycle. Responses (rd_data_valid, psum_valid) are single-cycle pulses
// with no back-pressure.
interface cim_unit_ctrl_if #(
  parameter int CORE_AW    = 3,
  parameter int ROW_AW     = 6,
  parameter int W_WIDTH    = 288,
  parameter int PSUM_WIDTH = 1008
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [CORE_AW-1:0]    wr_core;
  logic [ROW_AW-1:0]     wr_row;
  logic [W_WIDTH-1:0]    wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [CORE_AW-1:0]    rd_core;
  logic [ROW_AW-1:0]     rd_row;
  logic                  rd_data_valid;
  logic [W_WIDTH-1:0]    rd_data;
  logic                  cim_valid;
  logic                  cim_ready;
  logic [CORE_AW-1:0]    cim_core;
  logic                  psum_valid;
  logic [PSUM_WIDTH-1:0] psum;
  logic [CORE_AW-1:0]    psum_core;
  logic                  cim_err;

  modport master (
    output wr_valid, wr_core, wr_row, wr_data,
    output rd_valid, rd_core, rd_row,
    output cim_valid, cim_core,
    input  wr_ready, rd_ready, cim_ready,
    input  rd_data_valid, rd_data,
    input  psum_valid, psum, psum_core, cim_err
  );

  modport slave (
    input  wr_valid, wr_core, wr_row, wr_data,
    input  rd_valid, rd_core, rd_row,
    input  cim_valid, cim_core,
    output wr_ready, rd_ready, cim_ready,
    output rd_data_valid, rd_data,
    output psum_valid, psum, psum_core, cim_err
  );
endinterface

// File: rtl/cim_unit_ctrl.sv
// Scheduler and datapath mux between the host and NUM_CORES CIM cores.
// CIM requests take priority per core; writes beat reads on the one shared
// STD port; responses come back through tag pipelines of fixed latency.
module cim_unit_ctrl #(
  parameter int NUM_CORES  = 8,
  parameter int CORE_AW    = 3,
  parameter int ROWS       = 64,
  parameter int ROW_AW     = 6,
  parameter int W_WIDTH    = 288,
  parameter int PSUM_WIDTH = 1008,
  parameter int CIM_LAT    = 1,
  parameter int RD_LAT     = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  cim_unit_ctrl_if.slave                  host,
  output logic [NUM_CORES-1:0]            loaded,
  output logic [NUM_CORES-1:0]            core_stdw,
  output logic [NUM_CORES-1:0]            core_stdr,
  output logic [NUM_CORES-1:0]            core_cim_en,
  output logic [ROW_AW-1:0]               core_row,
  output logic [W_WIDTH-1:0]              core_wdata,
  input  logic [NUM_CORES*W_WIDTH-1:0]    core_wout,
  input  logic [NUM_CORES*PSUM_WIDTH-1:0] core_psum
);

  // Tag pipelines: stage 0 is loaded on accept, the last stage is the response.
  logic [CIM_LAT-1:0]              cim_v_q, cim_v_d;
  logic [CIM_LAT-1:0][CORE_AW-1:0] cim_core_q, cim_core_d;
  logic [CIM_LAT-1:0]              cim_err_q, cim_err_d;
  logic [RD_LAT-1:0]               rd_v_q, rd_v_d;
  logic [RD_LAT-1:0][CORE_AW-1:0]  rd_core_q, rd_core_d;
  logic [NUM_CORES-1:0]            loaded_q, loaded_d;

  logic rd_hit_cim, cim_acc, wr_busy, rd_busy, wr_gnt, rd_gnt, cim_tag_err;

  // Per-target hazard detection and grant decisions; nothing is granted in reset.
  always_comb begin
    rd_hit_cim = 1'b0;
    for (int k = 0; k < RD_LAT; k++)
      if (rd_v_q[k] && rd_core_q[k] == host.cim_core) rd_hit_cim = 1'b1;
    cim_acc = rst_n && host.cim_valid && !rd_hit_cim;
    wr_busy = cim_acc && (host.cim_core == host.wr_core);
    rd_busy = cim_acc && (host.cim_core == host.rd_core);
    for (int k = 0; k < CIM_LAT; k++) begin
      if (cim_v_q[k] && cim_core_q[k] == host.wr_core) wr_busy = 1'b1;
      if (cim_v_q[k] && cim_core_q[k] == host.rd_core) rd_busy = 1'b1;
    end
    for (int k = 0; k < RD_LAT; k++) begin
      if (rd_v_q[k] && rd_core_q[k] == host.wr_core) wr_busy = 1'b1;
      if (rd_v_q[k] && rd_core_q[k] == host.rd_core) rd_busy = 1'b1;
    end
    wr_gnt = rst_n && host.wr_valid && !wr_busy;
    rd_gnt = rst_n && host.rd_valid && !rd_busy && !wr_gnt;
  end

  assign host.cim_ready = rst_n && !rd_hit_cim;
  assign host.wr_ready  = wr_gnt;
  assign host.rd_ready  = rd_gnt;
  assign loaded         = loaded_q;

  // One-hot core strobes and the shared STD row/data bus; out-of-range indices strobe nothing.
  always_comb begin
    core_stdw   = '0;
    core_stdr   = '0;
    core_cim_en = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (cim_acc && host.cim_core == CORE_AW'(i)) core_cim_en[i] = 1'b1;
      if (wr_gnt && host.wr_core == CORE_AW'(i))   core_stdw[i]   = 1'b1;
      if (rd_gnt && host.rd_core == CORE_AW'(i))   core_stdr[i]   = 1'b1;
    end
    core_row   = wr_gnt ? host.wr_row : (rd_gnt ? host.rd_row : '0);
    core_wdata = wr_gnt ? host.wr_data : '0;
  end

  // Next state of tag pipelines and the loaded bitmap (row ROWS-1 set wins over row 0 clear).
  always_comb begin
    cim_tag_err = 1'b1;
    for (int i = 0; i < NUM_CORES; i++)
      if (host.cim_core == CORE_AW'(i)) cim_tag_err = ~loaded_q[i];
    cim_v_d[0]    = cim_acc;
    cim_core_d[0] = host.cim_core;
    cim_err_d[0]  = cim_tag_err;
    for (int k = 1; k < CIM_LAT; k++) begin
      cim_v_d[k]    = cim_v_q[k-1];
      cim_core_d[k] = cim_core_q[k-1];
      cim_err_d[k]  = cim_err_q[k-1];
    end
    rd_v_d[0]    = rd_gnt;
    rd_core_d[0] = host.rd_core;
    for (int k = 1; k < RD_LAT; k++) begin
      rd_v_d[k]    = rd_v_q[k-1];
      rd_core_d[k] = rd_core_q[k-1];
    end
    loaded_d = loaded_q;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (wr_gnt && host.wr_core == CORE_AW'(i)) begin
        if (host.wr_row == ROW_AW'(ROWS - 1))  loaded_d[i] = 1'b1;
        else if (host.wr_row == '0)            loaded_d[i] = 1'b0;
      end
    end
  end

  // Responses come straight from the last tag stage; data muxed from the tagged core.
  always_comb begin
    host.psum_valid    = cim_v_q[CIM_LAT-1];
    host.psum_core     = cim_v_q[CIM_LAT-1] ? cim_core_q[CIM_LAT-1] : '0;
    host.cim_err       = cim_v_q[CIM_LAT-1] & cim_err_q[CIM_LAT-1];
    host.psum          = '0;
    host.rd_data_valid = rd_v_q[RD_LAT-1];
    host.rd_data       = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (cim_v_q[CIM_LAT-1] && cim_core_q[CIM_LAT-1] == CORE_AW'(i))
        host.psum = core_psum[i*PSUM_WIDTH +: PSUM_WIDTH];
      if (rd_v_q[RD_LAT-1] && rd_core_q[RD_LAT-1] == CORE_AW'(i))
        host.rd_data = core_wout[i*W_WIDTH +: W_WIDTH];
    end
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cim_v_q    <= '0;
      cim_core_q <= '0;
      cim_err_q  <= '0;
      rd_v_q     <= '0;
      rd_core_q  <= '0;
      loaded_q   <= '0;
    end else begin
      cim_v_q    <= cim_v_d;
      cim_core_q <= cim_core_d;
      cim_err_q  <= cim_err_d;
      rd_v_q     <= rd_v_d;
      rd_core_q  <= rd_core_d;
      loaded_q   <= loaded_d;
    end
  end

endmodule

// File: tb/tb_cim_unit_ctrl.sv
// Bench for cim_unit_ctrl: directed scenarios followed by random traffic,
// checked against a time-based reference model (per-core busy windows,
// reference weight memory, expected-response queues).
module tb_cim_unit_ctrl;
  localparam int NUM_CORES  = 8;
  localparam int CORE_AW    = 3;
  localparam int ROWS       = 64;
  localparam int ROW_AW     = 6;
  localparam int W_WIDTH    = 288;
  localparam int PSUM_WIDTH = 1008;
  localparam int CIM_LAT    = 1;
  localparam int RD_LAT     = 1;

  typedef struct {
    int due;
    int core;
    bit err;
  } psum_exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cim_unit_ctrl_if #(.CORE_AW(CORE_AW), .ROW_AW(ROW_AW), .W_WIDTH(W_WIDTH),
                     .PSUM_WIDTH(PSUM_WIDTH)) h ();

  logic [NUM_CORES-1:0]            loaded, core_stdw, core_stdr, core_cim_en;
  logic [ROW_AW-1:0]               core_row;
  logic [W_WIDTH-1:0]              core_wdata;
  logic [NUM_CORES*W_WIDTH-1:0]    core_wout;
  logic [NUM_CORES*PSUM_WIDTH-1:0] core_psum;

  cim_unit_ctrl #(
    .NUM_CORES(NUM_CORES), .CORE_AW(CORE_AW), .ROWS(ROWS), .ROW_AW(ROW_AW),
    .W_WIDTH(W_WIDTH), .PSUM_WIDTH(PSUM_WIDTH), .CIM_LAT(CIM_LAT), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .host(h), .loaded(loaded),
    .core_stdw(core_stdw), .core_stdr(core_stdr), .core_cim_en(core_cim_en),
    .core_row(core_row), .core_wdata(core_wdata),
    .core_wout(core_wout), .core_psum(core_psum)
  );

  // ---------------- core stand-ins (RD_LAT = 1) ----------------
  logic [W_WIDTH-1:0] core_mem [NUM_CORES][ROWS];
  int                 core_rrow [NUM_CORES];

  always @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_stdw[i]) core_mem[i][core_row] <= core_wdata;
      if (core_stdr[i]) core_rrow[i] <= int'(core_row);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++)
      core_wout[i*W_WIDTH +: W_WIDTH] = core_mem[i][core_rrow[i]];
  end

  // ---------------- reference model / scoreboard ----------------
  int                 total = 0;
  int                 bad = 0;
  int                 cyc = 0;
  int                 cim_until [NUM_CORES];
  int                 rd_until [NUM_CORES];
  logic [W_WIDTH-1:0] ref_mem [NUM_CORES][ROWS];
  logic [NUM_CORES-1:0] ref_loaded = '0;
  psum_exp_t          psum_q[$];
  int                 rd_due_q[$];
  logic [W_WIDTH-1:0] exp_q[$];
  bit                 last_wg;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[319:0], exp[319:0]);
    end
  endtask

  function automatic logic [W_WIDTH-1:0] rand_w();
    logic [W_WIDTH-1:0] r;
    for (int k = 0; k + 32 <= W_WIDTH; k += 32) r[k +: 32] = $urandom();
    return r;
  endfunction

  function automatic bit std_busy(input int c, input bit cacc, input int cc);
    return (cacc && c == cc) || (cyc <= cim_until[c]) || (cyc <= rd_until[c]);
  endfunction

  // ---------------- driver: one clock cycle of requests ----------------
  task automatic step(input bit wv, input int wc, input int wrow, input logic [W_WIDTH-1:0] wd,
                      input bit rv, input int rc, input int rrow,
                      input bit cv, input int cc);
    bit cim_rdy, cacc, wg, rg, pv, dv;
    logic [NUM_CORES-1:0] e_w, e_r, e_c;
    psum_exp_t pe;
    @(negedge clk);
    h.wr_valid = wv;  h.wr_core = CORE_AW'(wc); h.wr_row = ROW_AW'(wrow); h.wr_data = wd;
    h.rd_valid = rv;  h.rd_core = CORE_AW'(rc); h.rd_row = ROW_AW'(rrow);
    h.cim_valid = cv; h.cim_core = CORE_AW'(cc);
    for (int k = 0; k + 32 <= NUM_CORES*PSUM_WIDTH; k += 32) core_psum[k +: 32] = $urandom();
    #1;
    cim_rdy = !(cyc <= rd_until[cc]);
    cacc = cv && cim_rdy;
    wg = wv && !std_busy(wc, cacc, cc);
    rg = rv && !wg && !std_busy(rc, cacc, cc);
    e_w = '0; e_r = '0; e_c = '0;
    if (wg)   e_w[wc] = 1'b1;
    if (rg)   e_r[rc] = 1'b1;
    if (cacc) e_c[cc] = 1'b1;
    chk("cim_ready", 1024'(h.cim_ready), 1024'(cim_rdy));
    chk("wr_ready", 1024'(h.wr_ready), 1024'(wg));
    chk("rd_ready", 1024'(h.rd_ready), 1024'(rg));
    chk("core_stdw", 1024'(core_stdw), 1024'(e_w));
    chk("core_stdr", 1024'(core_stdr), 1024'(e_r));
    chk("core_cim_en", 1024'(core_cim_en), 1024'(e_c));
    if (wg) begin
      chk("core_row_w", 1024'(core_row), 1024'(wrow));
      chk("core_wdata", 1024'(core_wdata), 1024'(wd));
    end else if (rg) begin
      chk("core_row_r", 1024'(core_row), 1024'(rrow));
    end
    chk("loaded", 1024'(loaded), 1024'(ref_loaded));
    pv = (psum_q.size() > 0) && (psum_q[0].due == cyc);
    chk("psum_valid", 1024'(h.psum_valid), 1024'(pv));
    if (pv) begin
      pe = psum_q.pop_front();
      chk("psum_core", 1024'(h.psum_core), 1024'(pe.core));
      chk("cim_err", 1024'(h.cim_err), 1024'(pe.err));
      chk("psum", 1024'(h.psum), 1024'(core_psum[pe.core*PSUM_WIDTH +: PSUM_WIDTH]));
    end
    dv = (rd_due_q.size() > 0) && (rd_due_q[0] == cyc);
    chk("rd_data_valid", 1024'(h.rd_data_valid), 1024'(dv));
    if (dv) begin
      void'(rd_due_q.pop_front());
      chk("rd_data", 1024'(h.rd_data), 1024'(exp_q.pop_front()));
    end
    if (cacc) begin
      pe.due = cyc + CIM_LAT; pe.core = cc; pe.err = !ref_loaded[cc];
      psum_q.push_back(pe);
      cim_until[cc] = cyc + CIM_LAT;
    end
    if (rg) begin
      rd_due_q.push_back(cyc + RD_LAT);
      exp_q.push_back(ref_mem[rc][rrow]);
      rd_until[rc] = cyc + RD_LAT;
    end
    if (wg) begin
      ref_mem[wc][wrow] = wd;
      if (wrow == ROWS - 1) ref_loaded[wc] = 1'b1;
      else if (wrow == 0)   ref_loaded[wc] = 1'b0;
    end
    last_wg = wg;
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psum_valid"}, 1024'(h.psum_valid), 1024'(0));
    chk({tag, "_psum"}, 1024'(h.psum), 1024'(0));
    chk({tag, "_psum_core"}, 1024'(h.psum_core), 1024'(0));
    chk({tag, "_cim_err"}, 1024'(h.cim_err), 1024'(0));
    chk({tag, "_rd_data_valid"}, 1024'(h.rd_data_valid), 1024'(0));
    chk({tag, "_rd_data"}, 1024'(h.rd_data), 1024'(0));
    chk({tag, "_loaded"}, 1024'(loaded), 1024'(0));
    chk({tag, "_strobes"}, 1024'({core_stdw, core_stdr, core_cim_en}), 1024'(0));
    chk({tag, "_readies"}, 1024'({h.wr_ready, h.rd_ready, h.cim_ready}), 1024'(0));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W_WIDTH-1:0] d3;
    int n;
    for (int i = 0; i < NUM_CORES; i++) begin cim_until[i] = -1; rd_until[i] = -1; end
    h.wr_valid = 0; h.wr_core = '0; h.wr_row = '0; h.wr_data = '0;
    h.rd_valid = 0; h.rd_core = '0; h.rd_row = '0;
    h.cim_valid = 0; h.cim_core = '0;
    core_psum = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // load core 2 with row index as data
    for (int r = 0; r < ROWS; r++) step(1, 2, r, W_WIDTH'(r), 0, 0, 0, 0, 0);
    idle(1);

    // CIM on core 2 for 10 cycles while loading core 5
    for (int r = 0; r < ROWS; r++) step(1, 5, r, W_WIDTH'(r), 0, 0, 0, r < 10, 2);
    idle(2);

    // CIM and write to core 3 in the same cycle: write stalls, then lands
    d3 = rand_w();
    step(1, 3, 10, d3, 0, 0, 0, 1, 3);
    n = 0;
    while (!last_wg && n < 10) begin
      step(1, 3, 10, d3, 0, 0, 0, 0, 0);
      n++;
    end
    chk("stall_bound", 1024'(n < 10), 1024'(1));
    step(0, 0, 0, '0, 1, 3, 10, 0, 0);
    idle(2);

    // read core 5 row 7 while the write targets busy core 1
    step(1, 1, 4, rand_w(), 1, 5, 7, 1, 1);
    idle(2);

    // CIM to unloaded core 6; rewrite row 0 of loaded core 2
    step(0, 0, 0, '0, 0, 0, 0, 1, 6);
    step(1, 2, 0, W_WIDTH'(0), 0, 0, 0, 0, 0);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, NUM_CORES-1), $urandom_range(0, ROWS-1), rand_w(),
           $urandom_range(0, 1), $urandom_range(0, NUM_CORES-1), $urandom_range(0, ROWS-1),
           $urandom_range(0, 3) != 0, $urandom_range(0, NUM_CORES-1));
    idle(3);

    // reset with CIM and read traffic in flight
    step(0, 0, 0, '0, 0, 0, 0, 1, 2);
    step(0, 0, 0, '0, 1, 5, 7, 1, 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    psum_q.delete(); rd_due_q.delete(); exp_q.delete();
    ref_loaded = '0;
    for (int i = 0; i < NUM_CORES; i++) begin cim_until[i] = -1; rd_until[i] = -1; end
    h.wr_valid = 0; h.rd_valid = 0; h.cim_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
